// File: rtl/sync_rx_pkg.sv
// Shared types and helpers for the synchronizer receive-side checker.
package sync_rx_pkg;

    // Data-settle tracker states
    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SETTLE = 2'd1,
        STABLE = 2'd2
    } state_t;

    // Width of the settle counter: must hold STABLE_CYC-1 with headroom
    function automatic int scnt_width(input int stable_cyc);
        return $clog2(stable_cyc) + 1;
    endfunction

    localparam int SCNT_W_DEFAULT = scnt_width(2);

endpackage

// File: rtl/sync_rx_checker_sat_counter.sv
// Saturating up-counter with synchronous clear; holds at all-ones.
module sat_counter #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         clr,
    input  logic         inc,
    output logic [W-1:0] q
);

    logic [W-1:0] r_q;

    // Count up on inc, stick at the maximum value, clear wins over inc
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_q <= '0;
        end else if (clr) begin
            r_q <= '0;
        end else if (inc && (r_q != {W{1'b1}})) begin
            r_q <= r_q + W'(1);
        end
    end

    assign q = r_q;

endmodule

// File: rtl/sync_rx_checker.sv
// Destination-side checker: captures words on pulse rising edges, checks
// them against an incrementing reference and flags data that changes again
// before it has settled.
module sync_rx_checker
    import sync_rx_pkg::*;
#(
    parameter int N          = 8,
    parameter int STABLE_CYC = 2,
    parameter int CNT_W      = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             ena,
    input  logic             clr_i,
    input  logic [N-1:0]     data_i,
    input  logic             pulse_i,
    output logic [N-1:0]     cap_o,
    output logic [CNT_W-1:0] evt_cnt_o,
    output logic [CNT_W-1:0] mism_cnt_o,
    output logic [CNT_W-1:0] glitch_cnt_o,
    output logic             busy_o,
    output logic             err_o
);

    localparam int SCNT_W = scnt_width(STABLE_CYC);
    localparam logic [SCNT_W-1:0] SCNT_LAST = SCNT_W'(STABLE_CYC - 1);

    // Counter slots: 0 = events, 1 = mismatches, 2 = glitches
    localparam int NUM_CNT = 3;

    logic             r_pulse_q;
    logic [N-1:0]     r_data_q;
    logic             r_first_q;
    logic [N-1:0]     r_cap;
    state_t           r_state;
    logic [SCNT_W-1:0] r_scnt;
    logic             r_busy;

    logic             w_edge;
    logic             w_chg;
    logic             w_mism;
    logic             w_glitch;
    logic [NUM_CNT-1:0] w_inc;
    logic [CNT_W-1:0] w_cnt [NUM_CNT];

    assign w_edge   = ena & pulse_i & ~r_pulse_q;
    assign w_chg    = (data_i != r_data_q);
    assign w_mism   = w_edge & r_first_q & (data_i != (r_cap + N'(1)));
    assign w_glitch = ena & (r_state == SETTLE) & w_chg;

    assign w_inc[0] = w_edge;
    assign w_inc[1] = w_mism;
    assign w_inc[2] = w_glitch;

    // Input history always tracks the bus so re-enabling never fakes an edge
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_pulse_q <= 1'b0;
            r_data_q  <= '0;
        end else begin
            r_pulse_q <= pulse_i;
            r_data_q  <= data_i;
        end
    end

    // Word capture on each enabled pulse rising edge
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cap     <= '0;
            r_first_q <= 1'b0;
        end else if (clr_i) begin
            r_cap     <= '0;
            r_first_q <= 1'b0;
        end else if (w_edge) begin
            r_cap     <= data_i;
            r_first_q <= 1'b1;
        end
    end

    // Settle tracker: a change inside the settle window is a glitch
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= IDLE;
            r_scnt  <= '0;
            r_busy  <= 1'b0;
        end else if (clr_i) begin
            r_state <= IDLE;
            r_scnt  <= '0;
            r_busy  <= 1'b0;
        end else if (ena) begin
            case (r_state)
                IDLE, STABLE: begin
                    if (w_chg) begin
                        r_state <= SETTLE;
                        r_scnt  <= '0;
                        r_busy  <= 1'b1;
                    end
                end
                SETTLE: begin
                    if (w_chg) begin
                        r_scnt <= '0;
                    end else if (r_scnt == SCNT_LAST) begin
                        r_state <= STABLE;
                        r_busy  <= 1'b0;
                    end else begin
                        r_scnt <= r_scnt + SCNT_W'(1);
                    end
                end
                default: begin
                    r_state <= IDLE;
                    r_scnt  <= '0;
                    r_busy  <= 1'b0;
                end
            endcase
        end
    end

    genvar gi;
    generate
        for (gi = 0; gi < NUM_CNT; gi++) begin : g_cnt
            sat_counter #(.W(CNT_W)) u_cnt (
                .clk   (clk),
                .rst_n (rst_n),
                .clr   (clr_i),
                .inc   (w_inc[gi]),
                .q     (w_cnt[gi])
            );
        end
    endgenerate

    assign cap_o        = r_cap;
    assign evt_cnt_o    = w_cnt[0];
    assign mism_cnt_o   = w_cnt[1];
    assign glitch_cnt_o = w_cnt[2];
    assign busy_o       = r_busy;
    assign err_o        = (w_cnt[1] != '0) | (w_cnt[2] != '0);

endmodule

// File: doc/sync_rx_checker.md
Name: sync_rx_checker

Overview:
- Destination-domain checker placed directly downstream of the synchronizer paths; consumes one selected synchronized data word plus the recovered pulse.
- On each pulse rising edge it captures the word and checks it against an incrementing-counter reference (source sends 0,1,2,... modulo 2^N).
- It independently watches the raw data bus for words that change again before settling (multi-bit incoherence or metastability), and reports saturating event, mismatch and glitch counts.

Parameters:
- N, 8, data word width
- STABLE_CYC, 2, minimum consecutive unchanged cycles for a data change to count as settled (>=1)
- CNT_W, 8, width of each saturating counter

Ports:
- clk  input  1  destination-domain clock
- rst_n  input  1  asynchronous active-low reset
- ena  input  1  block enable; low freezes counters and FSM
- clr_i  input  1  synchronous clear of counters, capture and FSM
- data_i  input  N  synchronized data under test
- pulse_i  input  1  synchronized transfer pulse/level; rising edge marks a new word
- cap_o  output  N  last captured word
- evt_cnt_o  output  CNT_W  number of pulse rising edges captured
- mism_cnt_o  output  CNT_W  captures not equal to previous capture + 1
- glitch_cnt_o  output  CNT_W  data changes occurring before settle
- busy_o  output  1  high while the FSM is in SETTLE
- err_o  output  1  sticky: mism_cnt_o != 0 or glitch_cnt_o != 0

Behaviour:
- Reset (rst_n low, async): all outputs 0; pulse_q=0, data_q=0, first_q=0, FSM=IDLE.
- clr_i=1 at an edge: same values as reset, except pulse_q and data_q load pulse_i and data_i. clr_i has priority over ena and every event.
- pulse_q and data_q always register pulse_i and data_i, even with ena low, so re-enabling never creates a spurious edge or change.
- Edge event: ena & pulse_i & ~pulse_q. At that clock edge: cap_o<=data_i; evt_cnt++.
  - If first_q=1 and data_i != cap_o+1 (mod 2^N), mism_cnt++.
  - first_q<=1 on the first event; the first event never counts as a mismatch.
- Outputs are registered: an event sampled at edge k is visible after edge k (1-cycle latency). A pulse held high counts once. Back-to-back pulses need pulse_i low for at least one cycle between them.
- Counters saturate at 2^CNT_W-1 and do not wrap. The reference wrap 2^N-1 -> 0 is not a mismatch.
- Change detect: chg = (data_i != data_q).
- FSM (holds when ena=0):
  - IDLE: chg -> SETTLE, scnt<=0.
  - SETTLE: chg -> glitch_cnt++, scnt<=0, stay. No chg and scnt==STABLE_CYC-1 -> STABLE. Otherwise scnt++.
  - STABLE: chg -> SETTLE, scnt<=0.
- busy_o = (state==SETTLE), registered with the state.
- err_o is combinational from the counter registers.
- An edge event and chg in the same cycle are processed independently; the capture uses the data_i value presented in that cycle.
- Reset asserted mid-SETTLE or mid-capture aborts immediately; there is no partial count.

Decomposition:
- Package sync_rx_pkg:
  - FSM state enum (IDLE=2'd0, SETTLE=2'd1, STABLE=2'd2)
  - localparam for the scnt width, $clog2(STABLE_CYC)+1
- Sub-module sat_counter #(W): ports clk, rst_n, clr, inc, q; increments and saturates. Instantiated three times (evt, mism, glitch).

Test Plan:
- Reset: hold rst_n=0 with data_i=8'hA5 and pulse_i toggling -> all outputs 0; after release the first pulse captures and evt_cnt_o=1.
- Counter sequence: send 0x00..0x05, each with a 1-cycle pulse and data stable 3 cycles before it -> evt_cnt_o=6, mism_cnt_o=0, glitch_cnt_o=0, cap_o=0x05, err_o=0.
- Wrap and mismatch: send 0xFE, 0xFF, 0x00, 0x07 -> mism_cnt_o=1 (at 0x07 only), err_o=1.
- Glitch: STABLE_CYC=2; data_i 0x00->0x0F->0xFF on consecutive cycles, then stable -> glitch_cnt_o=1, busy_o high for 3 cycles, then STABLE.
- Saturation: CNT_W=2, apply 5 pulses -> evt_cnt_o stays at 3. Then clr_i pulse -> all counts 0 and err_o=0.
- Enable freeze: ena=0 while 2 pulses and a data change occur -> counts unchanged. On re-enable with pulse_i held high -> no event is counted.
